result_framer: RTL
==================

RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the record queue depth (power of two, 2..16).
REQ-002 The block SHALL take parameter TS_W, default 48, as the timestamp width; it is fixed at 48 for this board.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- fpga_clk_i  in  1  system clock (CLK0 domain).
- reset_i  in  1  synchronous active-high reset.
- en_i  in  1  capture enable.
- data_ready_i  in  1  single-cycle pulse: sample valid.
- data_i  in  32  sample payload (ADC A/B pair).
- tag_i  in  4  source id (device index).
- clock_i  in  48  free-running timestamp counter.
- fifo_full_i  in  1  output FIFO full.
- fifo_wr_o  out  1  output FIFO write strobe.
- fifo_data_o  out  64  output FIFO word.
- overflow_cnt_o  out  16  dropped-record count.
- seq_o  out  8  next sequence number.
- idle_o  out  1  queue empty and FSM in IDLE.

Function
REQ-004 A capture event SHALL be a cycle with data_ready_i=1 and en_i=1; when en_i=0, data_ready_i SHALL be ignored, with no sequence change.
REQ-005 On each capture event the block SHALL form a record {tag_i, seq, clock_i, data_i} using the seq value of that cycle, then increment seq modulo 256 (255->0).
REQ-006 The block SHALL push a record into the queue if the queue is not full or a pop occurs in the same cycle; otherwise it SHALL drop the record and still increment seq.
REQ-007 overflow_cnt_o SHALL increment by 1 per dropped record and saturate at 16'hFFFF.
REQ-008 The FSM SHALL have three states: IDLE, HDR and DAT.
- IDLE: if the queue is non-empty, pop into the output register and go to HDR.
- HDR: header word presented; on a write, go to DAT.
- DAT: data word presented; on a write, pop the next record and go to HDR if the queue is non-empty, else go to IDLE.
REQ-009 The header word SHALL be {4'hA, tag[3:0], seq[7:0], ts[47:0]}.
REQ-010 The data word SHALL be {8'hC3, seq[7:0], 16'h0000, data[31:0]}.
REQ-011 fifo_data_o SHALL be registered, and fifo_wr_o SHALL equal (state==HDR or state==DAT) and !fifo_full_i, combinationally.
REQ-012 When no write occurs (fifo_full_i=1), the state and fifo_data_o SHALL hold unchanged.
REQ-013 With an empty queue and fifo_full_i=0, a capture in cycle N SHALL produce a header write in cycle N+2 and a data write in cycle N+3.
REQ-014 Back-to-back records SHALL stream with no idle cycle between the data word of one record and the header word of the next.
REQ-015 The two words of a record SHALL never be separated by words of another record.
REQ-016 idle_o SHALL be 1 exactly when the queue is empty and the state is IDLE.

Reset
REQ-017 While reset_i=1, the block SHALL clear the queue, set state=IDLE, seq=0, overflow_cnt_o=0, fifo_data_o=0 and fifo_wr_o=0.
REQ-018 A reset asserted mid-record SHALL abandon the record, even if only its header was written; the host discards the orphan header by its 4'hA sync nibble.
REQ-019 A capture event coinciding with reset_i=1 SHALL be discarded.

Structure
REQ-020 The shared package SHALL hold the sync constants (4'hA, 8'hC3), the FSM state encoding and the record width (4+8+48+32=92).
REQ-021 The record queue SHALL be the sub-module rf_fifo: a synchronous DEPTH x 92 first-word-fall-through FIFO with push, pop, full and empty.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single sample: data_i=32'h1234_5678, tag_i=2, clock_i=48'h10 at N -> cycle N+2 word 64'hA200_0000_0000_0010, cycle N+3 word 64'hC300_0000_1234_5678, then idle_o=1.
- Burst of 4 consecutive pulses, fifo_full_i=0 -> 8 consecutive writes, seq 0..3, overflow_cnt_o=0.
- fifo_full_i held at 1 during 6 pulses (DEPTH=4) -> 1 record in the output register, 4 queued, 1 dropped: overflow_cnt_o=1 and seq_o=6; after release, headers show seq 0,1,2,3,4 and the seq 5 gap is visible.
- fifo_full_i toggling every other cycle during a 3-record stream -> no word lost, duplicated or reordered, and fifo_wr_o never high while full.
- en_i=0 with 3 pulses -> no writes, and seq_o is unchanged.
- Reset asserted the cycle after a header write -> no data word, all outputs zero; the next capture carries seq=0.

Source files
------------

// File: rtl/result_framer_pkg.sv
// Shared definitions for the result framer: sync constants, FSM state
// encoding, the queued record layout and the two output word formatters.
package result_framer_pkg;

  localparam logic [3:0] HDR_SYNC = 4'hA;
  localparam logic [7:0] DAT_SYNC = 8'hC3;
  localparam int         REC_W    = 4 + 8 + 48 + 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  tag;
    logic [7:0]  seq;
    logic [47:0] ts;
    logic [31:0] data;
  } rec_t;

  function automatic logic [63:0] hdr_word(input rec_t r);
    return {HDR_SYNC, r.tag, r.seq, r.ts};
  endfunction

  function automatic logic [63:0] dat_word(input rec_t r);
    return {DAT_SYNC, r.seq, 16'h0000, r.data};
  endfunction

endpackage

// File: rtl/result_framer_fifo.sv
// rf_fifo: synchronous first-word-fall-through record queue.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i write side,
// pop_i/dout_o read side (dout_o valid whenever !empty_o), full_o, empty_o.
module rf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 92
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/result_framer.sv
// result_framer: stamps captured samples with tag/sequence/timestamp, queues
// them and streams each record to the output FIFO as a header+data word pair.
// Ports: fpga_clk_i, reset_i (sync, active-high); capture side en_i,
// data_ready_i, data_i, tag_i, clock_i; output side fifo_full_i, fifo_wr_o,
// fifo_data_o; status overflow_cnt_o, seq_o, idle_o.
//
// state   | meaning
// ST_IDLE | nothing in the output register; waiting for a queued record
// ST_HDR  | header word on fifo_data_o, waiting for a write
// ST_DAT  | data word on fifo_data_o, waiting for a write
module result_framer
  import result_framer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 48
) (
  input  logic            fpga_clk_i,
  input  logic            reset_i,
  input  logic            en_i,
  input  logic            data_ready_i,
  input  logic [31:0]     data_i,
  input  logic [3:0]      tag_i,
  input  logic [TS_W-1:0] clock_i,
  input  logic            fifo_full_i,
  output logic            fifo_wr_o,
  output logic [63:0]     fifo_data_o,
  output logic [15:0]     overflow_cnt_o,
  output logic [7:0]      seq_o,
  output logic            idle_o
);

  state_e      state_q, state_d;
  rec_t        rec_q, rec_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  seq_q;
  logic [15:0] ovf_q;
  rec_t        new_rec, head_rec;
  logic        capture, push, drop, pop, q_full, q_empty, wr;

  assign capture = en_i && data_ready_i;
  assign push    = capture && (!q_full || pop);
  assign drop    = capture && q_full && !pop;

  assign new_rec = '{tag: tag_i, seq: seq_q, ts: clock_i, data: data_i};

  rf_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk_i   (fpga_clk_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (new_rec),
    .dout_o  (head_rec),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Gated by reset so a word in flight is never written during reset.
  assign wr = (state_q == ST_HDR || state_q == ST_DAT) && !fifo_full_i && !reset_i;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          rec_d   = head_rec;
          data_d  = hdr_word(head_rec);
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (wr) begin
          data_d  = dat_word(rec_q);
          state_d = ST_DAT;
        end
      end
      ST_DAT: begin
        if (wr) begin
          if (!q_empty) begin
            pop     = 1'b1;
            rec_d   = head_rec;
            data_d  = hdr_word(head_rec);
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      rec_q   <= '0;
      data_q  <= '0;
      seq_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      data_q  <= data_d;
      if (capture) seq_q <= seq_q + 8'd1;
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign fifo_wr_o      = wr;
  assign fifo_data_o    = data_q;
  assign overflow_cnt_o = ovf_q;
  assign seq_o          = seq_q;
  assign idle_o         = q_empty && (state_q == ST_IDLE);

endmodule
